// File: rtl/lcd_overlay_pkg.sv
// ---------------------------------------------------------------------------
// lcd_overlay_pkg
// Shared definitions for the LCD overlay controller:
//   - coordinate widths (10-bit corner markers, 12-bit 4x accumulated centre)
//   - default park value for markers that have gone stale
//   - commit FSM state encoding
//   - the packed coordinate-set type and a helper that builds a parked set
// ---------------------------------------------------------------------------
package lcd_overlay_pkg;

    localparam int XY_W  = 10;
    localparam int CXY_W = 12;

    localparam logic [XY_W-1:0] PARK_XY_DEFAULT = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } ovl_state_e;

    // One complete marker set, in the order the detector presents it.
    typedef struct packed {
        logic [XY_W-1:0]  top_x;
        logic [XY_W-1:0]  top_y;
        logic [XY_W-1:0]  bottom_x;
        logic [XY_W-1:0]  bottom_y;
        logic [XY_W-1:0]  left_x;
        logic [XY_W-1:0]  left_y;
        logic [XY_W-1:0]  right_x;
        logic [XY_W-1:0]  right_y;
        logic [CXY_W-1:0] centre_x;
        logic [CXY_W-1:0] centre_y;
    } coord_set_t;

    // Parked set: every 10-bit field = park_xy, the centre = {park_xy, 2'b11}
    // so that the 4x accumulated centre lands on the same off-screen spot.
    function automatic coord_set_t park_set(input logic [XY_W-1:0] park_xy);
        coord_set_t s;
        s.top_x    = park_xy;
        s.top_y    = park_xy;
        s.bottom_x = park_xy;
        s.bottom_y = park_xy;
        s.left_x   = park_xy;
        s.left_y   = park_xy;
        s.right_x  = park_xy;
        s.right_y  = park_xy;
        s.centre_x = {park_xy, 2'b11};
        s.centre_y = {park_xy, 2'b11};
        return s;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises the raw active-low user key, waits for it to hold the same
// level for DEBOUNCE_CYCLES clocks, and emits a single-cycle press pulse on
// each debounced 1->0 (release->pressed) transition.
//
// Ports:
//   clk    in   pixel clock
//   rst_n  in   asynchronous active-low reset
//   key_n  in   raw key, active low, asynchronous to clk
//   press  out  1-cycle pulse per debounced press
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_key_meta;
    logic             r_key_sync;
    logic             r_key_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_stable_prev;
    logic             w_level_same;

    assign w_level_same = (r_key_sync == r_key_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_meta    <= 1'b1;
            r_key_sync    <= 1'b1;
            r_key_prev    <= 1'b1;
            r_cnt         <= '0;
            r_stable      <= 1'b1;
            r_stable_prev <= 1'b1;
        end else begin
            r_key_meta    <= key_n;
            r_key_sync    <= r_key_meta;
            r_key_prev    <= r_key_sync;
            r_stable_prev <= r_stable;
            // Any bounce restarts the count; the counter parks at CNT_MAX
            // while the level stays put.
            if (!w_level_same) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_level_same && (r_cnt == CNT_MAX)) begin
                r_stable <= r_key_sync;
            end
        end
    end

    assign press = r_stable_prev & ~r_stable;

endmodule

// File: rtl/lcd_overlay_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_overlay_ctrl
// Feeds marker coordinates and the overlay-enable control to the LCD
// timing/overlay driver. Detector sets land in shadow registers and are
// committed to the driver only at frame start so markers never tear. If no
// commit happens for STALE_FRAMES frames the markers are parked off-screen.
// A debounced key press toggles the overlay at the next frame start.
//
// Handshake: a coordinate set transfers on any clock edge where det_valid
// and det_ready are both high; det_ready is low only in the single COMMIT
// cycle, and det_valid may be raised or dropped at any time.
//
// Ports:
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   lcd_framesync      driver vertical sync (active low, resynchronised here)
//   key_n              raw user key (active low, asynchronous)
//   det_valid/ready    detector handshake
//   det_*_x/y          detector coordinates (10-bit, centre 12-bit)
//   *_pos_x/y          active coordinates to the driver
//   overlay_off        driver button_1: 1 = raw video, 0 = markers drawn
//   markers_stale      markers currently parked
//   dbg_state          commit FSM state
// ---------------------------------------------------------------------------
import lcd_overlay_pkg::*;

module lcd_overlay_ctrl #(
    parameter int              DEBOUNCE_CYCLES = 500000,
    parameter int              STALE_FRAMES    = 8,
    parameter logic [XY_W-1:0] PARK_XY         = PARK_XY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lcd_framesync,
    input  logic              key_n,
    input  logic              det_valid,
    output logic              det_ready,
    input  logic [XY_W-1:0]   det_top_x,
    input  logic [XY_W-1:0]   det_top_y,
    input  logic [XY_W-1:0]   det_bottom_x,
    input  logic [XY_W-1:0]   det_bottom_y,
    input  logic [XY_W-1:0]   det_left_x,
    input  logic [XY_W-1:0]   det_left_y,
    input  logic [XY_W-1:0]   det_right_x,
    input  logic [XY_W-1:0]   det_right_y,
    input  logic [CXY_W-1:0]  det_centre_x,
    input  logic [CXY_W-1:0]  det_centre_y,
    output logic [XY_W-1:0]   top_pos_x,
    output logic [XY_W-1:0]   top_pos_y,
    output logic [XY_W-1:0]   bottom_pos_x,
    output logic [XY_W-1:0]   bottom_pos_y,
    output logic [XY_W-1:0]   left_pos_x,
    output logic [XY_W-1:0]   left_pos_y,
    output logic [XY_W-1:0]   right_pos_x,
    output logic [XY_W-1:0]   right_pos_y,
    output logic [CXY_W-1:0]  centre_pos_x,
    output logic [CXY_W-1:0]  centre_pos_y,
    output logic              overlay_off,
    output logic              markers_stale,
    output logic [1:0]        dbg_state
);

    localparam int ST_W = $clog2(STALE_FRAMES + 1);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(STALE_FRAMES);
    localparam coord_set_t PARK_SET = park_set(PARK_XY);

    ovl_state_e       r_state;
    ovl_state_e       w_state_next;
    coord_set_t       r_shadow;
    coord_set_t       r_active;
    coord_set_t       w_det_set;
    logic [ST_W-1:0]  r_stale_cnt;
    logic             r_stale;
    logic             r_fs_meta;
    logic             r_fs_sync;
    logic             r_fs_prev;
    logic             r_pending_toggle;
    logic             r_overlay_off;
    logic             w_frame_start;
    logic             w_xfer;
    logic             w_press;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .press (w_press)
    );

    assign w_det_set = '{
        top_x:    det_top_x,    top_y:    det_top_y,
        bottom_x: det_bottom_x, bottom_y: det_bottom_y,
        left_x:   det_left_x,   left_y:   det_left_y,
        right_x:  det_right_x,  right_y:  det_right_y,
        centre_x: det_centre_x, centre_y: det_centre_y
    };

    assign det_ready     = (r_state != COMMIT);
    assign w_xfer        = det_valid && det_ready;
    // Falling edge of the synchronised vsync marks the start of a frame.
    assign w_frame_start = r_fs_prev & ~r_fs_sync;

    // ---------------- commit FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                // A set arriving on the frame-start cycle still makes this frame.
                if (w_xfer && w_frame_start) begin
                    w_state_next = COMMIT;
                end else if (w_xfer) begin
                    w_state_next = PENDING;
                end
            end
            PENDING: begin
                if (w_frame_start) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fs_meta        <= 1'b1;
            r_fs_sync        <= 1'b1;
            r_fs_prev        <= 1'b1;
            r_shadow         <= PARK_SET;
            r_active         <= PARK_SET;
            r_stale_cnt      <= '0;
            r_stale          <= 1'b1;
            r_pending_toggle <= 1'b0;
            r_overlay_off    <= 1'b1;
        end else begin
            r_fs_meta <= lcd_framesync;
            r_fs_sync <= r_fs_meta;
            r_fs_prev <= r_fs_sync;

            // Latest set wins while waiting for the frame boundary.
            if (w_xfer) begin
                r_shadow <= w_det_set;
            end

            if (r_state == COMMIT) begin
                r_active    <= r_shadow;
                r_stale_cnt <= '0;
                r_stale     <= 1'b0;
            end else if ((r_state == IDLE) && w_frame_start && !w_xfer) begin
                if (r_stale_cnt != ST_MAX) begin
                    r_stale_cnt <= r_stale_cnt + ST_W'(1);
                end
                // Park on the frame where the count reaches the limit (and
                // keep parked while it stays saturated).
                if (r_stale_cnt >= ST_MAX - ST_W'(1)) begin
                    r_active <= PARK_SET;
                    r_stale  <= 1'b1;
                end
            end

            // Presses collapse into one toggle applied at the frame boundary.
            if (w_frame_start && (r_pending_toggle || w_press)) begin
                r_overlay_off    <= ~r_overlay_off;
                r_pending_toggle <= 1'b0;
            end else if (w_press) begin
                r_pending_toggle <= 1'b1;
            end
        end
    end

    assign top_pos_x     = r_active.top_x;
    assign top_pos_y     = r_active.top_y;
    assign bottom_pos_x  = r_active.bottom_x;
    assign bottom_pos_y  = r_active.bottom_y;
    assign left_pos_x    = r_active.left_x;
    assign left_pos_y    = r_active.left_y;
    assign right_pos_x   = r_active.right_x;
    assign right_pos_y   = r_active.right_y;
    assign centre_pos_x  = r_active.centre_x;
    assign centre_pos_y  = r_active.centre_y;
    assign overlay_off   = r_overlay_off;
    assign markers_stale = r_stale;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_lcd_overlay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_overlay_ctrl
// Directed bench for lcd_overlay_ctrl with DEBOUNCE_CYCLES=4, STALE_FRAMES=3.
// Stimulus tasks push the expected output snapshot and the clock edge at
// which it must appear; a monitor pops an entry whenever the observed
// snapshot changes and compares both value and edge number. Any change with
// nothing queued is reported as an unexpected change.
// ---------------------------------------------------------------------------
module tb_lcd_overlay_ctrl;

    localparam int SW = 106;  // 8x10 + 2x12 coordinate bits + overlay_off + stale

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lcd_framesync;
    logic        key_n;
    logic        det_valid;
    logic        det_ready;
    logic [9:0]  det_top_x, det_top_y, det_bottom_x, det_bottom_y;
    logic [9:0]  det_left_x, det_left_y, det_right_x, det_right_y;
    logic [11:0] det_centre_x, det_centre_y;
    logic [9:0]  top_pos_x, top_pos_y, bottom_pos_x, bottom_pos_y;
    logic [9:0]  left_pos_x, left_pos_y, right_pos_x, right_pos_y;
    logic [11:0] centre_pos_x, centre_pos_y;
    logic        overlay_off;
    logic        markers_stale;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    logic [SW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    lcd_overlay_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .STALE_FRAMES    (3),
        .PARK_XY         (10'h3FF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lcd_framesync (lcd_framesync),
        .key_n         (key_n),
        .det_valid     (det_valid),
        .det_ready     (det_ready),
        .det_top_x     (det_top_x),
        .det_top_y     (det_top_y),
        .det_bottom_x  (det_bottom_x),
        .det_bottom_y  (det_bottom_y),
        .det_left_x    (det_left_x),
        .det_left_y    (det_left_y),
        .det_right_x   (det_right_x),
        .det_right_y   (det_right_y),
        .det_centre_x  (det_centre_x),
        .det_centre_y  (det_centre_y),
        .top_pos_x     (top_pos_x),
        .top_pos_y     (top_pos_y),
        .bottom_pos_x  (bottom_pos_x),
        .bottom_pos_y  (bottom_pos_y),
        .left_pos_x    (left_pos_x),
        .left_pos_y    (left_pos_y),
        .right_pos_x   (right_pos_x),
        .right_pos_y   (right_pos_y),
        .centre_pos_x  (centre_pos_x),
        .centre_pos_y  (centre_pos_y),
        .overlay_off   (overlay_off),
        .markers_stale (markers_stale),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / edge counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic logic [103:0] mkc(input int tx, input int ty, input int bx, input int by,
                                         input int lx, input int ly, input int rx, input int ry,
                                         input int cx, input int cy);
        return {tx[9:0], ty[9:0], bx[9:0], by[9:0], lx[9:0], ly[9:0], rx[9:0], ry[9:0],
                cx[11:0], cy[11:0]};
    endfunction

    function automatic logic [SW-1:0] snap_now();
        return {top_pos_x, top_pos_y, bottom_pos_x, bottom_pos_y, left_pos_x, left_pos_y,
                right_pos_x, right_pos_y, centre_pos_x, centre_pos_y, overlay_off, markers_stale};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [SW-1:0] e, input int edge_no);
        exp_q.push_back(e);
        exp_cyc_q.push_back(edge_no);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_coords(input logic [103:0] c);
        {det_top_x, det_top_y, det_bottom_x, det_bottom_y, det_left_x, det_left_y,
         det_right_x, det_right_y, det_centre_x, det_centre_y} = c;
    endtask

    task automatic send(input logic [103:0] c);
        @(negedge clk);
        drive_coords(c);
        det_valid = 1'b1;
        chk("ready_at_xfer", 128'(det_ready), 128'(1));
        @(negedge clk);
        det_valid = 1'b0;
    endtask

    // kind: 0 = no output change, 1 = change on 2nd edge after framesync is
    // first sampled (frame_start edge), 2 = one edge later (commit edge).
    task automatic frame(input bit xfer, input logic [103:0] c, input int kind,
                         input logic [SW-1:0] e);
        int ne;
        @(negedge clk);
        lcd_framesync = 1'b0;
        ne = cyc + 1;
        if (kind == 1) push_exp(e, ne + 2);
        else if (kind == 2) push_exp(e, ne + 3);
        @(negedge clk);
        @(negedge clk);  // frame_start cycle
        if (xfer) begin
            drive_coords(c);
            det_valid = 1'b1;
        end
        @(negedge clk);
        det_valid = 1'b0;
        repeat (2) @(negedge clk);
        lcd_framesync = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic key_low(input int n);
        @(negedge clk);
        key_n = 1'b0;
        repeat (n) @(negedge clk);
        key_n = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [SW-1:0] prev_snap;
    int            ready_low = 0;

    always @(posedge clk) begin
        logic [SW-1:0] cur;
        logic [SW-1:0] e;
        int            ec;
        #1;
        cur = snap_now();
        if (!rst_n || !mon_en) begin
            prev_snap = cur;
            ready_low = 0;
        end else begin
            if (cur !== prev_snap) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_change: got %0h was %0h (edge %0d)",
                             cur, prev_snap, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    chk("snapshot", 128'(cur), 128'(e));
                    chk("change_edge", 128'(cyc), 128'(ec));
                end
            end
            prev_snap = cur;
            if (!det_ready) begin
                ready_low++;
            end else if (ready_low != 0) begin
                chk("ready_low_cycles", 128'(ready_low), 128'(1));
                ready_low = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [103:0] park_c;
    logic [103:0] base_c;
    logic [103:0] c10, c20, c30;

    initial begin
        park_c = mkc(1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 4095, 4095);
        base_c = mkc(100, 50, 110, 300, 20, 150, 200, 160, 'h320, 'h1E0);
        c10    = mkc(10, 50, 110, 300, 20, 150, 200, 160, 'h320, 'h1E0);
        c20    = mkc(20, 50, 110, 300, 20, 150, 200, 160, 'h320, 'h1E0);
        c30    = mkc(30, 50, 110, 300, 20, 150, 200, 160, 'h320, 'h1E0);

        rst_n = 1'b0; lcd_framesync = 1'b1; key_n = 1'b1; det_valid = 1'b0;
        drive_coords('0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: reset state
        chk("rst_top_x", 128'(top_pos_x), 128'(10'h3FF));
        chk("rst_right_y", 128'(right_pos_y), 128'(10'h3FF));
        chk("rst_centre_x", 128'(centre_pos_x), 128'(12'hFFF));
        chk("rst_snapshot", 128'(snap_now()), 128'({park_c, 1'b1, 1'b1}));
        chk("rst_ready", 128'(det_ready), 128'(1));
        chk("rst_state", 128'(dbg_state), 128'(0));
        mon_en = 1'b1;

        // 2: mid-frame transfer commits only after frame start
        repeat (3) @(negedge clk);
        send(base_c);
        repeat (6) @(negedge clk);
        frame(1'b0, '0, 2, {base_c, 1'b1, 1'b0});

        // 3: latest wins; transfer on the frame-start cycle commits that frame
        send(c10);
        send(c20);
        frame(1'b0, '0, 2, {c20, 1'b1, 1'b0});
        frame(1'b1, c30, 2, {c30, 1'b1, 1'b0});

        // 4: three empty frames park the markers, next commit clears stale
        frame(1'b0, '0, 0, '0);
        frame(1'b0, '0, 0, '0);
        frame(1'b0, '0, 1, {park_c, 1'b1, 1'b1});
        send(base_c);
        frame(1'b0, '0, 2, {base_c, 1'b1, 1'b0});
        frame(1'b0, '0, 0, '0);
        frame(1'b0, '0, 0, '0);
        frame(1'b0, '0, 1, {park_c, 1'b1, 1'b1});

        // 5: key debounce and frame-aligned toggle
        key_low(3);
        repeat (12) @(negedge clk);
        frame(1'b0, '0, 0, '0);
        key_low(10);
        repeat (12) @(negedge clk);
        frame(1'b0, '0, 1, {park_c, 1'b0, 1'b1});
        key_low(10);
        repeat (10) @(negedge clk);
        key_low(10);
        repeat (10) @(negedge clk);
        frame(1'b0, '0, 1, {park_c, 1'b1, 1'b1});
        frame(1'b0, '0, 0, '0);

        // 6: reset while PENDING discards the shadow set
        key_low(10);
        repeat (10) @(negedge clk);
        send(c20);
        chk("pending_state", 128'(dbg_state), 128'(1));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_snapshot", 128'(snap_now()), 128'({park_c, 1'b1, 1'b1}));
        chk("midrst_state", 128'(dbg_state), 128'(0));
        frame(1'b0, '0, 0, '0);
        chk("post_rst_stale", 128'(markers_stale), 128'(1));
        chk("post_rst_overlay", 128'(overlay_off), 128'(1));

        repeat (10) @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_overlay_ctrl.md
Name: lcd_overlay_ctrl

Overview:
- Sequences the corner/centre marker coordinates and the overlay-enable control that feed the LCD timing/overlay driver.
- Accepts coordinate sets from the shape-detection block over a valid/ready handshake and holds them in shadow registers.
- Commits them to the driver only at frame start, so markers never tear mid-frame. Parks the markers when detections go stale.
- Debounces the user key into a frame-aligned overlay on/off toggle.

Parameters:
- DEBOUNCE_CYCLES, 500000: clk cycles the key must be stable before it counts as a press (20 ms at 25 MHz).
- STALE_FRAMES, 8: consecutive frames without a commit before the markers are parked.
- PARK_XY, 10'h3FF: parked value for 10-bit coordinates; the 12-bit centre parks at {PARK_XY,2'b11}.

Ports:
- clk  in  1  pixel clock, same clock as the LCD driver
- rst_n  in  1  asynchronous active-low reset
- lcd_framesync  in  1  driver vertical sync, active low
- key_n  in  1  raw user key, active low, asynchronous
- det_valid  in  1  detector coordinate set valid
- det_ready  out  1  controller can accept a set
- det_top_x, det_top_y, det_bottom_x, det_bottom_y, det_left_x, det_left_y, det_right_x, det_right_y  in  10 each  detector coordinates
- det_centre_x, det_centre_y  in  12 each  centre coordinate, 4x accumulated
- top_pos_x … right_pos_y  out  10 each  active coordinates to the driver
- centre_pos_x, centre_pos_y  out  12 each  active centre coordinates
- overlay_off  out  1  drives the driver's button_1 input; 1 = raw video, 0 = markers drawn
- markers_stale  out  1  markers are currently parked

Behaviour:
- Reset:
  - All position outputs = park values; overlay_off=1; markers_stale=1; det_ready=1.
  - FSM=IDLE, stale counter=0, debounce counter=0, pending_toggle=0.
- Frame start:
  - lcd_framesync passes through a 2-flop synchroniser.
  - frame_start is a 1-cycle pulse on the synchronised 1→0 edge.
- Handshake:
  - A transfer occurs when det_valid && det_ready; all ten coordinates are written into the shadow registers.
  - det_ready = (state != COMMIT).
  - Latest wins: a new transfer while PENDING overwrites the shadow registers.
- FSM:
  - IDLE: a transfer goes to PENDING. frame_start with no transfer increments the stale counter (saturating at STALE_FRAMES).
  - PENDING: frame_start goes to COMMIT.
  - COMMIT: lasts exactly 1 cycle. Shadow is copied to the active outputs, the stale counter is cleared, markers_stale goes to 0, and the FSM returns to IDLE.
  - Commit latency: active outputs change on the 2nd clk edge after the frame_start pulse.
  - Transfer and frame_start in the same cycle while IDLE or PENDING: the transfer is captured first, then the FSM goes to COMMIT, so the new data commits this frame.
  - frame_start while in COMMIT cannot occur (it is a single-cycle state); if it does, it is ignored.
- Stale:
  - When the stale counter reaches STALE_FRAMES on a frame_start, all active outputs load park values and markers_stale=1 in the same cycle.
  - The counter holds at STALE_FRAMES until the next commit.
- Key (handled in key_debounce):
  - key_n passes through a 2-flop synchroniser.
  - The counter resets on any change of the synchronised level and counts while the level is stable.
  - At DEBOUNCE_CYCLES-1 the stable level is registered. A 1→0 transition of that stable level produces a 1-cycle press pulse.
  - A press sets pending_toggle.
  - On frame_start with pending_toggle: overlay_off inverts and pending_toggle clears.
  - Press and frame_start in the same cycle: the toggle is applied at that frame_start.
  - Multiple presses within one frame still give a single toggle.
- Widths: the stale counter is $clog2(STALE_FRAMES+1) bits; the debounce counter is $clog2(DEBOUNCE_CYCLES) bits. No arithmetic on coordinates; they pass through unchanged.
- Reset mid-operation returns immediately to the reset values above; a pending shadow set is discarded.

Decomposition:
- Shared package lcd_overlay_pkg holds:
  - the coordinate width constants XY_W=10 and CXY_W=12;
  - the park constants;
  - the FSM state enum {IDLE, PENDING, COMMIT}.
- One sub-module, key_debounce (clk, rst_n, key_n, press), parameterised by DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4, STALE_FRAMES=3 in bench):
1. Release reset and check all outputs: positions = 10'h3FF / 12'hFFF, overlay_off=1, markers_stale=1, det_ready=1.
2. Transfer top=(100,50), centre=(0x320,0x1E0) mid-frame -> outputs unchanged until framesync falls. Then top_pos=(100,50), centre=(0x320,0x1E0), markers_stale=0 on the 2nd edge after the sync pulse, and det_ready=0 for exactly one cycle.
3. Two transfers in one frame, top_x=10 then top_x=20 -> top_pos_x=20 at commit. A transfer in the same cycle as frame_start, top_x=30 -> commits 30 that frame.
4. No transfers for 3 frames after a commit -> parked at the 3rd frame_start, markers_stale=1. The next transfer commits normally and clears stale.
5. Key low for 3 cycles then high -> no toggle. Key low for 10 cycles -> overlay_off flips 1→0 at the next frame_start only. Two clean presses in one frame -> single toggle.
6. Assert rst_n low while PENDING -> outputs park. After release, the following frame_start commits nothing (markers_stale stays 1).
